// File: rtl/wb_matrix_fb.sv
// wb_matrix_fb: double-buffered Wishbone LED-matrix framebuffer with row scanner.
// Ports: clk, reset (sync, active-high); i_wb_cyc/stb/we/addr/sel/wdata bus requests;
//        o_wb_ack/o_wb_stall/o_wb_rdata bus responses; o_row_sel/o_row_data displayed row;
//        o_frame_start pulse as row 0 begins; o_swap_pending completed frame awaiting swap.
module wb_matrix_fb #(
  parameter int WB_DATA_WIDTH = 32,
  parameter int REG_COUNT = 8,
  parameter int WB_ADDR_WIDTH = $clog2(REG_COUNT),
  parameter int WB_SEL_WIDTH = WB_DATA_WIDTH / 8,
  parameter int SCAN_DIV = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wb_cyc,
  input  logic                     i_wb_stb,
  input  logic                     i_wb_we,
  input  logic [WB_ADDR_WIDTH-1:0] i_wb_addr,
  input  logic [WB_SEL_WIDTH-1:0]  i_wb_sel,
  input  logic [WB_DATA_WIDTH-1:0] i_wb_wdata,
  output logic                     o_wb_ack,
  output logic                     o_wb_stall,
  output logic [WB_DATA_WIDTH-1:0] o_wb_rdata,
  output logic [WB_ADDR_WIDTH-1:0] o_row_sel,
  output logic [WB_DATA_WIDTH-1:0] o_row_data,
  output logic                     o_frame_start,
  output logic                     o_swap_pending
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] div_last = DW'(SCAN_DIV - 1);
  localparam logic [WB_ADDR_WIDTH-1:0] row_last = WB_ADDR_WIDTH'(REG_COUNT - 1);
  logic [WB_DATA_WIDTH-1:0] mem [2][REG_COUNT];
  logic bank;
  logic ack;
  logic pending;
  logic [DW-1:0] div;
  logic accept;
  logic addr_ok;
  logic div_end;
  logic wrap;
  assign accept = i_wb_cyc && i_wb_stb && !pending;
  assign addr_ok = 32'(i_wb_addr) < REG_COUNT;
  assign div_end = div == div_last;
  assign wrap = div_end && o_row_sel == row_last;
  assign o_wb_stall = pending;
  assign o_swap_pending = pending;
  // An ack still in flight is dropped when the master abandons the cycle.
  assign o_wb_ack = ack && i_wb_cyc;
  // The bus always sees the back bank (!bank); the scanner reads the front bank (bank).
  always_ff @(posedge clk) begin
    if (reset) begin
      mem <= '{default: '0};
      bank <= 1'b0;
      ack <= 1'b0;
      pending <= 1'b0;
      div <= '0;
      o_row_sel <= '0;
      o_row_data <= '0;
      o_wb_rdata <= '0;
      o_frame_start <= 1'b0;
    end else begin
      ack <= accept;
      o_wb_rdata <= (accept && !i_wb_we && addr_ok) ? mem[!bank][i_wb_addr] : '0;
      if (accept && i_wb_we && addr_ok)
        for (int s = 0; s < WB_SEL_WIDTH; s++)
          if (i_wb_sel[s]) mem[!bank][i_wb_addr][s*8 +: 8] <= i_wb_wdata[s*8 +: 8];
      div <= div_end ? '0 : div + 1'b1;
      if (div_end) o_row_sel <= wrap ? '0 : o_row_sel + 1'b1;
      o_frame_start <= wrap;
      o_row_data <= mem[bank][o_row_sel];
      // Swap only at the frame boundary; a stalled bus cannot set pending while it is already set.
      if (wrap && pending) bank <= !bank;
      pending <= (wrap && pending) ? 1'b0 : (accept && i_wb_we && i_wb_addr == row_last) ? 1'b1 : pending;
    end
  end
endmodule

// File: doc/wb_matrix_fb.md
WB_MATRIX_FB -- requirements
Module: wb_matrix_fb

Interface
REQ-001 SHALL have parameter WB_DATA_WIDTH, default 32, bus data width (8 pixels x 4-bit colour per row).
REQ-002 SHALL have parameter REG_COUNT, default 8, number of row registers per bank.
REQ-003 SHALL have parameter WB_ADDR_WIDTH, default $clog2(REG_COUNT), word address width.
REQ-004 SHALL have parameter WB_SEL_WIDTH, default WB_DATA_WIDTH/8, byte-select width.
REQ-005 SHALL have parameter SCAN_DIV, default 1024, clk cycles per displayed row (minimum 2).
REQ-006 SHALL have ports:
 clk  in  1  clock, all logic on rising edge
 reset  in  1  synchronous, active-high
 i_wb_cyc  in  1  bus cycle
 i_wb_stb  in  1  request strobe
 i_wb_we  in  1  1=write, 0=read
 i_wb_addr  in  WB_ADDR_WIDTH  row index
 i_wb_sel  in  WB_SEL_WIDTH  byte enables
 i_wb_wdata  in  WB_DATA_WIDTH  write data
 o_wb_ack  out  1  request completion
 o_wb_stall  out  1  request not accepted this cycle
 o_wb_rdata  out  WB_DATA_WIDTH  read data, valid with ack
 o_row_sel  out  WB_ADDR_WIDTH  row being displayed
 o_row_data  out  WB_DATA_WIDTH  pixels of displayed row
 o_frame_start  out  1  one-cycle pulse, row 0 begins
 o_swap_pending  out  1  completed frame waiting for swap

Function
REQ-007 SHALL hold two banks of REG_COUNT words (front = displayed, back = bus-visible); 1-bit bank select chooses front.
REQ-008 Request accepted when i_wb_cyc && i_wb_stb && !o_wb_stall.
REQ-009 Accepted write SHALL update back[i_wb_addr] byte-wise per i_wb_sel; bytes with sel=0 unchanged.
REQ-010 Accepted read SHALL return back[addr] on o_wb_rdata registered, same cycle as ack.
REQ-011 o_wb_ack SHALL assert exactly one cycle after each accepted request, one ack per request; back-to-back requests give continuous ack.
REQ-012 o_wb_ack SHALL be forced 0 in a cycle where i_wb_cyc is 0 (aborted cycle drops outstanding ack).
REQ-013 Accepted write to address REG_COUNT-1 SHALL set swap_pending the next cycle.
REQ-014 While swap_pending=1, o_wb_stall SHALL be 1 (combinational from swap_pending); otherwise 0.
REQ-015 Scan divider counts 0..SCAN_DIV-1 and wraps; at terminal count o_row_sel increments, wrapping REG_COUNT-1 -> 0.
REQ-016 On the wrap to row 0: o_frame_start pulses 1 cycle; if swap_pending, bank select toggles and swap_pending clears in that same edge.
REQ-017 Swap only at frame boundary; never mid-frame (no tearing).
REQ-018 After swap, back bank is the previously displayed frame (no copy); writer rewrites all rows.
REQ-019 o_row_data SHALL be front[o_row_sel], registered, updated the cycle after o_row_sel or bank changes (1-cycle latency).
REQ-020 Addresses >= REG_COUNT (non-power-of-2 REG_COUNT) SHALL be acked, writes ignored, reads return 0.
REQ-021 Write to REG_COUNT-1 accepted in same cycle as frame wrap SHALL set swap_pending without swapping; swap occurs next frame.
REQ-022 Reads SHALL not affect swap_pending.

Reset
REQ-023 On reset: both banks all-zero, bank select 0, swap_pending 0, divider 0, o_row_sel 0, o_row_data 0, o_wb_ack 0, o_wb_rdata 0, o_frame_start 0, o_wb_stall 0.
REQ-024 Reset mid-transaction SHALL drop any pending ack; reset dominates all other updates in the same cycle.

Verification
REQ-025 Write rows 0..7 = 0x00666600,0x06000060,... back-to-back, stb held -> ack on 8 consecutive cycles, stall rises after row 7 accepted, o_swap_pending=1.
REQ-026 After REQ-025 sequence, run to next frame wrap -> o_frame_start pulse, stall drops, o_row_data for row 0 = 0x00666600 one cycle later, row 2 shows 0x60500506.
REQ-027 Write 0xAABBCCDD sel=4'b0101 to row 3 holding 0x11223344 -> read row 3 returns 0x11BB33DD.
REQ-028 Issue write to row 7 while stall=1 -> no ack, data not written until swap, then accepted and acked.
REQ-029 Drop i_wb_cyc the cycle after an accepted request -> no ack; reset asserted mid-scan -> o_row_sel=0, outputs zero next cycle.
REQ-030 SCAN_DIV=4: o_row_sel advances every 4 cycles, o_frame_start every 32 cycles.
